// File: rtl/pc_adder_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_adder_sequencer_if
// Description : Bundles the fetch-side request signals, the shared PC-adder
//               bus and the PC/status outputs of the PC adder sequencer.
//               master : the sequencer (drives adder operands, pc, busy,
//                        redirect; receives requests and the adder sum).
//               slave  : fetch stage plus external adder (drives requests and
//                        the sum; observes operands and PC).
// Signals     : stall, branch_req, branch_offset[15:0], jump_req,
//               jump_target[25:0], add_a[31:0], add_b[31:0], add_sum[31:0],
//               pc[31:0], busy, redirect
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_adder_sequencer_if;
    logic        stall;
    logic        branch_req;
    logic [15:0] branch_offset;
    logic        jump_req;
    logic [25:0] jump_target;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic [31:0] pc;
    logic        busy;
    logic        redirect;

    modport master (
        input  stall, branch_req, branch_offset, jump_req, jump_target, add_sum,
        output add_a, add_b, pc, busy, redirect
    );

    modport slave (
        output stall, branch_req, branch_offset, jump_req, jump_target, add_sum,
        input  add_a, add_b, pc, busy, redirect
    );
endinterface
`default_nettype wire

// File: rtl/pc_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_adder_sequencer
// Description : Owns the MIPS program counter and time-shares one external
//               32-bit adder between PC+4 and branch-target computation.
//               Sequential and jump updates take one cycle; a taken branch
//               takes two (PC+4 captured first, then PC+4 + offset*4).
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - pc_adder_sequencer_if.master (requests, adder bus,
//                        pc / busy / redirect outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_adder_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] INC      = 32'd4
) (
    input  wire                        clk,
    input  wire                        rst_n,
    pc_adder_sequencer_if.master       bus
);

    // Two-bit one-hot style encoding so corrupted values are recognisable
    // and steered back to RUN.
    localparam logic [1:0] c_st_run = 2'b01;
    localparam logic [1:0] c_st_br2 = 2'b10;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc4_q;
    logic [15:0] r_off_q;
    logic        r_redirect;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;

    // Adder operands depend only on state and registers, never on the
    // request inputs, so the external adder path stays short.
    always_comb begin
        w_add_a = r_pc;
        w_add_b = INC;
        if (r_state == c_st_br2) begin
            w_add_a = r_pc4_q;
            w_add_b = {{14{r_off_q[15]}}, r_off_q, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_run;
            r_pc       <= RESET_PC;
            r_pc4_q    <= 32'd0;
            r_off_q    <= 16'd0;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    r_redirect <= 1'b0;
                    if (!bus.stall) begin
                        if (bus.jump_req) begin
                            // Region bits come from PC+4, not the current PC.
                            r_pc       <= {bus.add_sum[31:28], bus.jump_target, 2'b00};
                            r_redirect <= 1'b1;
                        end else if (bus.branch_req) begin
                            // First half of a branch: save PC+4 and the offset;
                            // PC holds until the target is summed next cycle.
                            r_pc4_q <= bus.add_sum;
                            r_off_q <= bus.branch_offset;
                            r_state <= c_st_br2;
                        end else begin
                            r_pc <= bus.add_sum;
                        end
                    end
                end
                c_st_br2: begin
                    if (!bus.stall) begin
                        r_pc       <= bus.add_sum;
                        r_redirect <= 1'b1;
                        r_state    <= c_st_run;
                    end
                end
                default: begin
                    r_state    <= c_st_run;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign bus.add_a    = w_add_a;
    assign bus.add_b    = w_add_b;
    assign bus.pc       = r_pc;
    assign bus.busy     = (r_state == c_st_br2);
    assign bus.redirect = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pc_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_adder_sequencer
// Description : Directed self-checking bench for pc_adder_sequencer. Models
//               the external adder combinationally and checks PC sequencing,
//               jump/branch redirects, wrap-around, stalls and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_adder_sequencer;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    pc_adder_sequencer_if bus ();

    // External combinational adder.
    assign bus.add_sum = bus.add_a + bus.add_b;

    pc_adder_sequencer #(
        .RESET_PC (32'h0000_3000),
        .INC      (32'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.stall         = 1'b0;
        bus.branch_req    = 1'b0;
        bus.branch_offset = 16'h0000;
        bus.jump_req      = 1'b0;
        bus.jump_target   = 26'h0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] exp_pc;
        clear_inputs();
        rst_n = 1'b0;
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc: got %h exp %h", bus.pc, 32'h0000_3000); end
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        n_chk++; if (bus.redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b exp 0", bus.redirect); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h0000_3000 + 32'(4 * i);
            n_chk++; if (bus.pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, bus.pc, exp_pc); end
            n_chk++; if (bus.busy !== 1'b0 || bus.redirect !== 1'b0) begin n_err++; $display("FAIL seq_flags[%0d]: got busy=%b redirect=%b exp 0/0", i, bus.busy, bus.redirect); end
            idle_step();
        end
    endtask

    task automatic test_branch_negative;
        do_reset();
        repeat (4) idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3010) begin n_err++; $display("FAIL br_pre_pc: got %h exp %h", bus.pc, 32'h0000_3010); end
        bus.branch_req    = 1'b1;
        bus.branch_offset = 16'hFFFC;
        idle_step();
        bus.branch_req = 1'b0;
        n_chk++; if (bus.pc !== 32'h0000_3010) begin n_err++; $display("FAIL br1_pc: got %h exp %h", bus.pc, 32'h0000_3010); end
        n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL br1_busy: got %b exp 1", bus.busy); end
        n_chk++; if (bus.add_a !== 32'h0000_3014) begin n_err++; $display("FAIL br1_add_a: got %h exp %h", bus.add_a, 32'h0000_3014); end
        n_chk++; if (bus.add_b !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL br1_add_b: got %h exp %h", bus.add_b, 32'hFFFF_FFF0); end
        n_chk++; if (bus.redirect !== 1'b0) begin n_err++; $display("FAIL br1_redirect: got %b exp 0", bus.redirect); end
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3004) begin n_err++; $display("FAIL br2_pc: got %h exp %h", bus.pc, 32'h0000_3004); end
        n_chk++; if (bus.redirect !== 1'b1) begin n_err++; $display("FAIL br2_redirect: got %b exp 1", bus.redirect); end
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL br2_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_jump_priority;
        do_reset();
        repeat (8) idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3020) begin n_err++; $display("FAIL jmp_pre_pc: got %h exp %h", bus.pc, 32'h0000_3020); end
        bus.jump_req      = 1'b1;
        bus.branch_req    = 1'b1;
        bus.jump_target   = 26'h000_0C40;
        bus.branch_offset = 16'h0010;
        idle_step();
        bus.jump_req   = 1'b0;
        bus.branch_req = 1'b0;
        n_chk++; if (bus.pc !== 32'h0000_3100) begin n_err++; $display("FAIL jmp_pc: got %h exp %h", bus.pc, 32'h0000_3100); end
        n_chk++; if (bus.redirect !== 1'b1) begin n_err++; $display("FAIL jmp_redirect: got %b exp 1", bus.redirect); end
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL jmp_busy: got %b exp 0", bus.busy); end
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3104) begin n_err++; $display("FAIL jmp_next_pc: got %h exp %h", bus.pc, 32'h0000_3104); end
        n_chk++; if (bus.redirect !== 1'b0) begin n_err++; $display("FAIL jmp_next_redirect: got %b exp 0", bus.redirect); end
    endtask

    task automatic test_wrap;
        // From 0x3000: target = 0x3004 + sext(0xF3FE)*4 = 0x3004 - 0x3008.
        do_reset();
        bus.branch_req    = 1'b1;
        bus.branch_offset = 16'hF3FE;
        idle_step();
        bus.branch_req = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wrap_br_busy: got %b exp 1", bus.busy); end
        idle_step();
        n_chk++; if (bus.pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_br_pc: got %h exp %h", bus.pc, 32'hFFFF_FFFC); end
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_seq_pc: got %h exp %h", bus.pc, 32'h0000_0000); end
        bus.branch_req    = 1'b1;
        bus.branch_offset = 16'h7FFF;
        idle_step();
        bus.branch_req = 1'b0;
        n_chk++; if (bus.add_a !== 32'h0000_0004) begin n_err++; $display("FAIL maxoff_add_a: got %h exp %h", bus.add_a, 32'h0000_0004); end
        n_chk++; if (bus.add_b !== 32'h0001_FFFC) begin n_err++; $display("FAIL maxoff_add_b: got %h exp %h", bus.add_b, 32'h0001_FFFC); end
        idle_step();
        n_chk++; if (bus.pc !== 32'h0002_0000) begin n_err++; $display("FAIL maxoff_pc: got %h exp %h", bus.pc, 32'h0002_0000); end
    endtask

    task automatic test_stall;
        do_reset();
        repeat (4) idle_step();
        bus.branch_req    = 1'b1;
        bus.branch_offset = 16'h0004;
        idle_step();
        bus.branch_req  = 1'b0;
        bus.stall       = 1'b1;
        bus.jump_req    = 1'b1;
        bus.jump_target = 26'h3FF_FFFF;
        for (int i = 0; i < 3; i++) begin
            idle_step();
            n_chk++; if (bus.pc !== 32'h0000_3010 || bus.busy !== 1'b1) begin n_err++; $display("FAIL stall_br2[%0d]: got pc=%h busy=%b exp 00003010/1", i, bus.pc, bus.busy); end
            n_chk++; if (bus.add_a !== 32'h0000_3014 || bus.add_b !== 32'h0000_0010) begin n_err++; $display("FAIL stall_ops[%0d]: got %h/%h exp 00003014/00000010", i, bus.add_a, bus.add_b); end
            n_chk++; if (bus.redirect !== 1'b0) begin n_err++; $display("FAIL stall_redirect[%0d]: got %b exp 0", i, bus.redirect); end
        end
        bus.stall = 1'b0;
        idle_step();
        bus.jump_req = 1'b0;
        n_chk++; if (bus.pc !== 32'h0000_3024) begin n_err++; $display("FAIL stall_done_pc: got %h exp %h", bus.pc, 32'h0000_3024); end
        n_chk++; if (bus.redirect !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL stall_done_flags: got redirect=%b busy=%b exp 1/0", bus.redirect, bus.busy); end
        bus.stall = 1'b1;
        idle_step();
        bus.stall = 1'b0;
        n_chk++; if (bus.pc !== 32'h0000_3024) begin n_err++; $display("FAIL run_stall_pc: got %h exp %h", bus.pc, 32'h0000_3024); end
        n_chk++; if (bus.redirect !== 1'b0) begin n_err++; $display("FAIL run_stall_redirect: got %b exp 0", bus.redirect); end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.branch_req    = 1'b1;
        bus.branch_offset = 16'h0004;
        idle_step();
        bus.branch_req = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ar_pre_busy: got %b exp 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.pc !== 32'h0000_3000) begin n_err++; $display("FAIL ar_pc: got %h exp %h", bus.pc, 32'h0000_3000); end
        n_chk++; if (bus.busy !== 1'b0 || bus.redirect !== 1'b0) begin n_err++; $display("FAIL ar_flags: got busy=%b redirect=%b exp 0/0", bus.busy, bus.redirect); end
        idle_step();
        rst_n = 1'b1;
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3004) begin n_err++; $display("FAIL ar_resume1: got %h exp %h", bus.pc, 32'h0000_3004); end
        idle_step();
        n_chk++; if (bus.pc !== 32'h0000_3008) begin n_err++; $display("FAIL ar_resume2: got %h exp %h", bus.pc, 32'h0000_3008); end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_branch_negative();
        test_jump_priority();
        test_wrap();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
